fifo_uart_tx: RTL and testbench

- Downstream drain stage for the 8-bit, 32-deep byte FIFO.
- Pops bytes through the FIFO's read interface (`rd_en`, `empty`, show-ahead `dout`) and serialises each one as a UART frame on `tx`.
- Frame format: start bit, 8 data bits LSB first, optional even parity bit, one stop bit.
- Gives the FIFO a continuous consumer, so buffered bytes leave the chip at a fixed baud rate.

---
 rtl/fifo_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : Drain stage for a show-ahead byte FIFO. Pops one byte at a
//                time and sends it as a UART frame (start, DATA_W data bits
//                LSB first, optional even parity, one stop bit) on tx.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  logic [2:0]        state_q,     state_d;
  logic [DATA_W-1:0] shreg_q,     shreg_d;
  logic              par_q,       par_d;
  logic [BAUD_W-1:0] baud_q,      baud_d;
  logic [BIT_W-1:0]  bit_q,       bit_d;
  logic              tx_q,        tx_d;
  logic              rd_en_q,     rd_en_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic w_baud_done;

  assign w_baud_done = (baud_q == BAUD_LAST);

  // Next-state logic for the frame sequencer; tx is registered so that the
  // line only ever changes right after a clock edge.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rd_en_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        // Data and its parity are captured on the same edge as the pop, so
        // later changes on fifo_dout cannot disturb the frame.
        if (tx_en && !fifo_empty) begin
          shreg_d = fifo_dout;
          par_d   = ^fifo_dout;
          rd_en_d = 1'b1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = S_START;
      end

      S_START: begin
        if (w_baud_done) begin
          tx_d    = shreg_q[0];
          bit_d   = '0;
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (w_baud_done) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            // Next bit to appear is the one that lands in bit 0 after this shift.
            tx_d = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_PARITY: begin
        if (w_baud_done) begin
          tx_d    = 1'b1;
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (w_baud_done) begin
          baud_d      = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any frame and forces the line high at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      baud_q      <= '0;
      bit_q       <= '0;
      tx_q        <= 1'b1;
      rd_en_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rd_en_q     <= rd_en_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_rd_en = rd_en_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Directed self-checking bench for fifo_uart_tx. Two instances
//                (parity off / parity on), each fed by a small FIFO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic tx_en0, tx_en1;

  // Show-ahead FIFO models
  logic [7:0] mem0 [0:255];
  logic [7:0] mem1 [0:255];
  logic [7:0] wr0 = 8'd0, rd0 = 8'd0, wr1 = 8'd0, rd1 = 8'd0;
  logic       empty0, empty1;
  logic [7:0] dout0, dout1;
  assign empty0 = (wr0 == rd0);
  assign empty1 = (wr1 == rd1);
  assign dout0  = mem0[rd0];
  assign dout1  = mem1[rd1];

  logic        rd_en0, rd_en1, tx0, tx1, busy0, busy1;
  logic [15:0] fc0, fc1;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(0)) dut0 (
    .clk(clk), .rstn(rstn), .tx_en(tx_en0), .fifo_empty(empty0),
    .fifo_dout(dout0), .fifo_rd_en(rd_en0), .tx(tx0), .busy(busy0),
    .frame_cnt(fc0)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1)) dut1 (
    .clk(clk), .rstn(rstn), .tx_en(tx_en1), .fifo_empty(empty1),
    .fifo_dout(dout1), .fifo_rd_en(rd_en1), .tx(tx1), .busy(busy1),
    .frame_cnt(fc1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pop monitors: count pops, pops on an empty FIFO, and pulses wider than 1.
  int   pops0 = 0, under0 = 0, wide0 = 0, pops1 = 0, under1 = 0, wide1 = 0;
  logic prev0 = 1'b0, prev1 = 1'b0;
  always @(posedge clk) begin
    if (rd_en0 === 1'b1) begin
      pops0 <= pops0 + 1;
      if (empty0) under0 <= under0 + 1; else rd0 <= rd0 + 8'd1;
      if (prev0) wide0 <= wide0 + 1;
    end
    if (rd_en1 === 1'b1) begin
      pops1 <= pops1 + 1;
      if (empty1) under1 <= under1 + 1; else rd1 <= rd1 + 8'd1;
      if (prev1) wide1 <= wide1 + 1;
    end
    prev0 <= (rd_en0 === 1'b1);
    prev1 <= (rd_en1 === 1'b1);
  end

  int total = 0;
  int bad   = 0;

  task automatic push(input int sel, input logic [7:0] b);
    if (sel == 0) begin mem0[wr0] = b; wr0 = wr0 + 8'd1; end
    else          begin mem1[wr1] = b; wr1 = wr1 + 8'd1; end
  endtask

  function automatic logic txs(input int sel);
    return (sel == 0) ? tx0 : tx1;
  endfunction

  function automatic logic bsy(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  // Wait for a start bit, sample every bit near its middle, then count the
  // remaining busy cycles. len = cycles from tx falling to busy dropping.
  task automatic capture(input int sel, output logic ok, output logic [7:0] data,
                         output logic par, output logic stopb, output int fall,
                         output int len);
    int n;
    ok = 1'b0; data = 8'h00; par = 1'b0; stopb = 1'b0; fall = 0; len = 0;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (txs(sel) === 1'b0) break;
    end
    if (n == 400) return;
    fall = cyc;
    len  = 1;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      len += CPB;
      data[i] = txs(sel);
    end
    if (sel == 1) begin
      repeat (CPB) @(negedge clk);
      len += CPB;
      par = tx1;
    end
    repeat (CPB) @(negedge clk);
    len += CPB;
    stopb = txs(sel);
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bsy(sel) !== 1'b1) break;
      len++;
    end
    ok = (n < 100);
  endtask

  task automatic test_reset;
    rstn = 1'b0; tx_en0 = 1'b0; tx_en1 = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (tx0 !== 1'b1)      begin bad++; $display("FAIL reset_tx0 got=%b want=1", tx0); end
    total++; if (busy0 !== 1'b0)    begin bad++; $display("FAIL reset_busy0 got=%b want=0", busy0); end
    total++; if (fc0 !== 16'd0)     begin bad++; $display("FAIL reset_cnt0 got=%h want=0000", fc0); end
    total++; if (rd_en0 !== 1'b0)   begin bad++; $display("FAIL reset_rd0 got=%b want=0", rd_en0); end
    total++; if (tx1 !== 1'b1)      begin bad++; $display("FAIL reset_tx1 got=%b want=1", tx1); end
    total++; if (busy1 !== 1'b0)    begin bad++; $display("FAIL reset_busy1 got=%b want=0", busy1); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame;
    logic ok, pb, sb; logic [7:0] d; int f, l, p;
    p = pops0;
    push(0, 8'hA5);
    tx_en0 = 1'b1;
    capture(0, ok, d, pb, sb, f, l);
    total++; if (!ok || d !== 8'hA5) begin bad++; $display("FAIL single_data got=%h ok=%b want=a5", d, ok); end
    total++; if (sb !== 1'b1)        begin bad++; $display("FAIL single_stop got=%b want=1", sb); end
    total++; if (l != 40)            begin bad++; $display("FAIL single_len got=%0d want=40", l); end
    total++; if (pops0 - p != 1)     begin bad++; $display("FAIL single_pops got=%0d want=1", pops0 - p); end
    total++; if (wide0 != 0)         begin bad++; $display("FAIL single_pulse_width got=%0d want=0", wide0); end
    total++; if (fc0 !== 16'd1)      begin bad++; $display("FAIL single_cnt got=%h want=0001", fc0); end
    total++; if (tx0 !== 1'b1 || busy0 !== 1'b0) begin bad++; $display("FAIL single_idle got tx=%b busy=%b want 1/0", tx0, busy0); end
    tx_en0 = 1'b0;
  endtask

  task automatic test_parity;
    logic ok1, ok2, p1, p2, s1, s2; logic [7:0] d1, d2; int f1, f2, l1, l2, p;
    p = pops1;
    push(1, 8'hA5);
    push(1, 8'h07);
    tx_en1 = 1'b1;
    capture(1, ok1, d1, p1, s1, f1, l1);
    capture(1, ok2, d2, p2, s2, f2, l2);
    total++; if (!ok1 || d1 !== 8'hA5)  begin bad++; $display("FAIL par_data1 got=%h want=a5", d1); end
    total++; if (p1 !== 1'b0)           begin bad++; $display("FAIL par_bit1 got=%b want=0", p1); end
    total++; if (!ok2 || d2 !== 8'h07)  begin bad++; $display("FAIL par_data2 got=%h want=07", d2); end
    total++; if (p2 !== 1'b1)           begin bad++; $display("FAIL par_bit2 got=%b want=1", p2); end
    total++; if (s1 !== 1'b1 || s2 !== 1'b1) begin bad++; $display("FAIL par_stop got=%b%b want=11", s1, s2); end
    total++; if (l1 != 44 || l2 != 44)  begin bad++; $display("FAIL par_len got=%0d,%0d want=44", l1, l2); end
    total++; if (f2 - f1 != 46)         begin bad++; $display("FAIL par_spacing got=%0d want=46", f2 - f1); end
    total++; if (fc1 !== 16'd2 || pops1 - p != 2) begin bad++; $display("FAIL par_count got cnt=%h pops=%0d want 0002/2", fc1, pops1 - p); end
  endtask

  task automatic test_burst;
    logic ok, pb, sb; logic [7:0] d; int f, l, p, u; logic [15:0] fs;
    tx_en0 = 1'b0;
    for (int i = 0; i < 32; i++) push(0, 8'(i));
    p = pops0; u = under0; fs = fc0;
    tx_en0 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      capture(0, ok, d, pb, sb, f, l);
      total++; if (!ok || d !== 8'(i)) begin bad++; $display("FAIL burst_byte%0d got=%h ok=%b want=%h", i, d, ok, 8'(i)); end
    end
    total++; if (pops0 - p != 32)      begin bad++; $display("FAIL burst_pops got=%0d want=32", pops0 - p); end
    total++; if (under0 != u)          begin bad++; $display("FAIL burst_pop_empty got=%0d want=%0d", under0, u); end
    total++; if (fc0 !== fs + 16'd32)  begin bad++; $display("FAIL burst_cnt got=%h want=%h", fc0, fs + 16'd32); end
    repeat (20) @(negedge clk);
    total++; if (pops0 - p != 32 || wr0 !== rd0) begin bad++; $display("FAIL burst_extra_pop got=%0d want=32", pops0 - p); end
    total++; if (tx0 !== 1'b1 || busy0 !== 1'b0) begin bad++; $display("FAIL burst_idle got tx=%b busy=%b want 1/0", tx0, busy0); end
    tx_en0 = 1'b0;
  endtask

  task automatic test_tx_en_gating;
    int p, n; logic [15:0] fs;
    tx_en0 = 1'b0;
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    p = pops0; fs = fc0;
    repeat (20) @(negedge clk);
    total++; if (pops0 - p != 0)  begin bad++; $display("FAIL gate_nopop got=%0d want=0", pops0 - p); end
    total++; if (tx0 !== 1'b1 || busy0 !== 1'b0) begin bad++; $display("FAIL gate_idle got tx=%b busy=%b want 1/0", tx0, busy0); end
    tx_en0 = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (tx0 === 1'b0) break;
    end
    total++; if (n == 50) begin bad++; $display("FAIL gate_start got=timeout want=start_bit"); end
    repeat (10) @(negedge clk);
    tx_en0 = 1'b0;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (busy0 === 1'b0) break;
    end
    repeat (30) @(negedge clk);
    total++; if (pops0 - p != 1)      begin bad++; $display("FAIL gate_pops got=%0d want=1", pops0 - p); end
    total++; if (fc0 !== fs + 16'd1)  begin bad++; $display("FAIL gate_cnt got=%h want=%h", fc0, fs + 16'd1); end
    total++; if (8'(wr0 - rd0) !== 8'd2) begin bad++; $display("FAIL gate_remaining got=%0d want=2", 8'(wr0 - rd0)); end
  endtask

  task automatic test_reset_mid_frame;
    logic ok, pb, sb; logic [7:0] d; int f, l, p, n;
    push(1, 8'h3C);
    push(1, 8'h5A);
    p = pops1;
    tx_en1 = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (tx1 === 1'b0) break;
    end
    repeat (12) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    total++; if (tx1 !== 1'b1)    begin bad++; $display("FAIL rst_mid_tx got=%b want=1", tx1); end
    total++; if (busy1 !== 1'b0)  begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy1); end
    total++; if (fc1 !== 16'd0)   begin bad++; $display("FAIL rst_mid_cnt got=%h want=0000", fc1); end
    total++; if (rd_en1 !== 1'b0) begin bad++; $display("FAIL rst_mid_rd got=%b want=0", rd_en1); end
    repeat (5) @(negedge clk);
    total++; if (pops1 - p != 1)  begin bad++; $display("FAIL rst_mid_pops got=%0d want=1", pops1 - p); end
    rstn = 1'b1;
    capture(1, ok, d, pb, sb, f, l);
    total++; if (!ok || d !== 8'h5A || pb !== 1'b0) begin bad++; $display("FAIL rst_next_frame got=%h par=%b want=5a par=0", d, pb); end
    total++; if (pops1 - p != 2 || wide1 != 0) begin bad++; $display("FAIL rst_next_pop got pops=%0d wide=%0d want 2/0", pops1 - p, wide1); end
    total++; if (fc1 !== 16'd1)   begin bad++; $display("FAIL rst_next_cnt got=%h want=0001", fc1); end
    tx_en1 = 1'b0;
  endtask

  task automatic test_wrap;
    logic ok, pb, sb; logic [7:0] d; int f, l;
    tx_en0 = 1'b0;
    @(negedge clk);
    force dut0.frame_cnt_q = 16'hFFFE;
    @(posedge clk);
    #1 release dut0.frame_cnt_q;
    @(negedge clk);
    total++; if (fc0 !== 16'hFFFE) begin bad++; $display("FAIL wrap_preset got=%h want=fffe", fc0); end
    tx_en0 = 1'b1;
    capture(0, ok, d, pb, sb, f, l);
    total++; if (!ok || d !== 8'h22) begin bad++; $display("FAIL wrap_data1 got=%h want=22", d); end
    total++; if (fc0 !== 16'hFFFF)   begin bad++; $display("FAIL wrap_cnt1 got=%h want=ffff", fc0); end
    capture(0, ok, d, pb, sb, f, l);
    total++; if (!ok || d !== 8'h33) begin bad++; $display("FAIL wrap_data2 got=%h want=33", d); end
    total++; if (fc0 !== 16'h0000)   begin bad++; $display("FAIL wrap_cnt2 got=%h want=0000", fc0); end
    tx_en0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_burst();
    test_tx_en_gating();
    test_reset_mid_frame();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
